// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/ALU slice: opcodes, function codes,
// ALU-op classes, ALU control codes and the decoded control bundle.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU-op classes produced by the control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSV   = 2'b11;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    // Decoded main-control bundle
    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       branch_eq;
        logic       branch_ne;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_decode_alu_if.sv
// Instruction/operand bus into the decode+ALU slice and its decoded outputs.
// master = instruction source, slave = mips_decode_alu.
interface mips_decode_alu_if;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        clear;

    logic        regdst;
    logic        alusrc;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        regwrite;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] alu_out_q;
    logic        zero_q;

    modport master (
        output instr, rs_data, rt_data, clear,
        input  regdst, alusrc, memread, memwrite, memtoreg, regwrite,
               branch_eq, branch_ne, jump, aluop, aluctl, alu_out, zero,
               alu_out_q, zero_q
    );

    modport slave (
        input  instr, rs_data, rt_data, clear,
        output regdst, alusrc, memread, memwrite, memtoreg, regwrite,
               branch_eq, branch_ne, jump, aluop, aluctl, alu_out, zero,
               alu_out_q, zero_q
    );
endinterface

// File: rtl/mips_alu_core.sv
// 32-bit ALU: add/sub wrap, bitwise ops, signed set-less-than.
// Unused control codes yield zero, and zero_o always reflects out_o.
module mips_alu_core
    import mips_pkg::*;
(
    input  logic [3:0]  aluctl_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] out_o,
    output logic        zero_o
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign a_s = a_i;
    assign b_s = b_i;

    // Operation select; anything not decoded falls to zero
    always_comb begin
        out_o = '0;
        case (aluctl_i)
            ALU_AND: out_o = a_i & b_i;
            ALU_OR:  out_o = a_i | b_i;
            ALU_ADD: out_o = a_i + b_i;
            ALU_SUB: out_o = a_i - b_i;
            ALU_SLT: out_o = {31'd0, (a_s < b_s)};
            ALU_NOR: out_o = ~(a_i | b_i);
            ALU_XOR: out_o = a_i ^ b_i;
            default: out_o = '0;
        endcase
    end

    assign zero_o = (out_o == 32'd0);

endmodule

// File: rtl/mips_decode_alu.sv
// Decode + execute slice: main control decoder, ALU-control decoder,
// ALU core and a one-cycle result register with synchronous clear.
module mips_decode_alu
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mips_decode_alu_if.slave  bus
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [9:0]  unused_instr;
    ctrl_t       ctrl;
    logic [3:0]  aluctl;
    logic [31:0] op_b;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] alu_out_d, alu_out_q;
    logic        zero_d, zero_q;

    assign opcode       = bus.instr[31:26];
    assign funct        = bus.instr[5:0];
    assign imm          = bus.instr[15:0];
    assign unused_instr = bus.instr[25:16];

    // Main control decode; unknown opcodes decode as a NOP
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch_eq = 1'b1;
                ctrl.aluop     = ALUOP_SUB;
            end
            OP_BNE: begin
                ctrl.branch_ne = 1'b1;
                ctrl.aluop     = ALUOP_SUB;
            end
            OP_J:    ctrl.jump = 1'b1;
            default: ctrl = '0;
        endcase
    end

    // ALU-control decode from op class, falling to funct for R-type
    always_comb begin
        aluctl = ALU_AND;
        case (ctrl.aluop)
            ALUOP_ADD: aluctl = ALU_ADD;
            ALUOP_SUB: aluctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  aluctl = ALU_ADD;
                    FN_SUB:  aluctl = ALU_SUB;
                    FN_AND:  aluctl = ALU_AND;
                    FN_OR:   aluctl = ALU_OR;
                    FN_XOR:  aluctl = ALU_XOR;
                    FN_NOR:  aluctl = ALU_NOR;
                    FN_SLT:  aluctl = ALU_SLT;
                    default: aluctl = ALU_AND;
                endcase
            end
            default: aluctl = ALU_AND;
        endcase
    end

    assign op_b = ctrl.alusrc ? sext16(imm) : bus.rt_data;

    mips_alu_core u_alu (
        .aluctl_i (aluctl),
        .a_i      (bus.rs_data),
        .b_i      (op_b),
        .out_o    (alu_out),
        .zero_o   (zero)
    );

    // Next-state for the result register: clear wins over normal load
    always_comb begin
        alu_out_d = bus.clear ? 32'd0 : alu_out;
        zero_d    = bus.clear ? 1'b0  : zero;
    end

    // Result register, asynchronously reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
        end
    end

    assign bus.regdst    = ctrl.regdst;
    assign bus.alusrc    = ctrl.alusrc;
    assign bus.memread   = ctrl.memread;
    assign bus.memwrite  = ctrl.memwrite;
    assign bus.memtoreg  = ctrl.memtoreg;
    assign bus.regwrite  = ctrl.regwrite;
    assign bus.branch_eq = ctrl.branch_eq;
    assign bus.branch_ne = ctrl.branch_ne;
    assign bus.jump      = ctrl.jump;
    assign bus.aluop     = ctrl.aluop;
    assign bus.aluctl    = aluctl;
    assign bus.alu_out   = alu_out;
    assign bus.zero      = zero;
    assign bus.alu_out_q = alu_out_q;
    assign bus.zero_q    = zero_q;

endmodule

// File: tb/tb_mips_decode_alu.sv
// Directed bench for mips_decode_alu: control decode, ALU ops, result
// register latency, synchronous clear and asynchronous reset.
module tb_mips_decode_alu;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [8:0] ctl;

    mips_decode_alu_if bus();

    mips_decode_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {regdst, alusrc, memread, memwrite, memtoreg, regwrite, beq, bne, jump}
    assign ctl = {bus.regdst, bus.alusrc, bus.memread, bus.memwrite, bus.memtoreg,
                  bus.regwrite, bus.branch_eq, bus.branch_ne, bus.jump};

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {OP_RTYPE, 20'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'd0, imm};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.instr   = ins;
        bus.rs_data = a;
        bus.rt_data = b;
        #1;
    endtask

    task automatic test_reset;
        bus.instr = itype(OP_ADDI, 16'd9); bus.rs_data = 32'd1; bus.rt_data = 32'd0; bus.clear = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.alu_out_q !== 32'd0) begin n_fail++; $display("FAIL reset_q0: got %h want 0", bus.alu_out_q); end
        n_checks++; if (bus.zero_q !== 1'b0) begin n_fail++; $display("FAIL reset_z0: got %b want 0", bus.zero_q); end
        n_checks++; if (bus.alu_out !== 32'd10) begin n_fail++; $display("FAIL reset_comb: got %h want 0000000a", bus.alu_out); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.alu_out_q !== 32'd0) begin n_fail++; $display("FAIL reset_held: got %h want 0", bus.alu_out_q); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw;
        drive(itype(OP_LW, 16'hFFFC), 32'h100, 32'hDEAD);
        n_checks++; if (ctl !== 9'b011011000) begin n_fail++; $display("FAIL lw_ctl: got %b want 011011000", ctl); end
        n_checks++; if (bus.aluop !== 2'b00) begin n_fail++; $display("FAIL lw_aluop: got %b want 00", bus.aluop); end
        n_checks++; if (bus.aluctl !== 4'b0010) begin n_fail++; $display("FAIL lw_aluctl: got %b want 0010", bus.aluctl); end
        n_checks++; if (bus.alu_out !== 32'hFC) begin n_fail++; $display("FAIL lw_out: got %h want 000000fc", bus.alu_out); end
        @(posedge clk); #1;
        n_checks++; if (bus.alu_out_q !== 32'hFC) begin n_fail++; $display("FAIL lw_q: got %h want 000000fc", bus.alu_out_q); end
        n_checks++; if (bus.zero_q !== 1'b0) begin n_fail++; $display("FAIL lw_zq: got %b want 0", bus.zero_q); end
    endtask

    task automatic test_rtype_sub;
        drive(rtype(FN_SUB), 32'h1234, 32'h1234);
        n_checks++; if (ctl !== 9'b100001000) begin n_fail++; $display("FAIL sub_ctl: got %b want 100001000", ctl); end
        n_checks++; if (bus.aluop !== 2'b10) begin n_fail++; $display("FAIL sub_aluop: got %b want 10", bus.aluop); end
        n_checks++; if (bus.aluctl !== 4'b0110) begin n_fail++; $display("FAIL sub_aluctl: got %b want 0110", bus.aluctl); end
        n_checks++; if (bus.alu_out !== 32'd0 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL sub_out: got %h/%b want 0/1", bus.alu_out, bus.zero); end
        @(posedge clk); #1;
        n_checks++; if (bus.zero_q !== 1'b1) begin n_fail++; $display("FAIL sub_zq: got %b want 1", bus.zero_q); end
    endtask

    task automatic test_slt;
        drive(rtype(FN_SLT), 32'hFFFFFFFF, 32'd1);
        n_checks++; if (bus.aluctl !== 4'b0111) begin n_fail++; $display("FAIL slt_aluctl: got %b want 0111", bus.aluctl); end
        n_checks++; if (bus.alu_out !== 32'd1) begin n_fail++; $display("FAIL slt_neg: got %h want 1", bus.alu_out); end
        drive(rtype(FN_SLT), 32'd1, 32'hFFFFFFFF);
        n_checks++; if (bus.alu_out !== 32'd0 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL slt_swap: got %h/%b want 0/1", bus.alu_out, bus.zero); end
    endtask

    task automatic test_branch;
        drive(itype(OP_BEQ, 16'h0010), 32'd5, 32'd5);
        n_checks++; if (ctl !== 9'b000000100) begin n_fail++; $display("FAIL beq_ctl: got %b want 000000100", ctl); end
        n_checks++; if (bus.zero !== 1'b1 || bus.aluctl !== 4'b0110) begin n_fail++; $display("FAIL beq_zero: got %b/%b want 1/0110", bus.zero, bus.aluctl); end
        drive(itype(OP_BNE, 16'h0010), 32'd5, 32'd6);
        n_checks++; if (ctl !== 9'b000000010) begin n_fail++; $display("FAIL bne_ctl: got %b want 000000010", ctl); end
        n_checks++; if (bus.zero !== 1'b0 || bus.alu_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL bne_out: got %h/%b want ffffffff/0", bus.alu_out, bus.zero); end
    endtask

    task automatic test_nop_and_default;
        drive({6'b111111, 26'h3FFFFFF}, 32'd3, 32'd4);
        n_checks++; if (ctl !== 9'd0 || bus.aluop !== 2'b00) begin n_fail++; $display("FAIL nop_ctl: got %b/%b want 0/00", ctl, bus.aluop); end
        n_checks++; if (bus.aluctl !== 4'b0010) begin n_fail++; $display("FAIL nop_aluctl: got %b want 0010", bus.aluctl); end
        drive(rtype(6'b000000), 32'hF0F0F0F0, 32'hFF00FF00);
        n_checks++; if (bus.aluctl !== 4'b0000 || bus.alu_out !== 32'hF000F000) begin n_fail++; $display("FAIL fn0_and: got %b/%h want 0000/f000f000", bus.aluctl, bus.alu_out); end
    endtask

    task automatic test_logic_ops;
        drive(rtype(FN_AND), 32'hF0F0F0F0, 32'hFF00FF00);
        n_checks++; if (bus.alu_out !== 32'hF000F000) begin n_fail++; $display("FAIL and: got %h want f000f000", bus.alu_out); end
        drive(rtype(FN_OR), 32'hF0F0F0F0, 32'hFF00FF00);
        n_checks++; if (bus.alu_out !== 32'hFFF0FFF0 || bus.aluctl !== 4'b0001) begin n_fail++; $display("FAIL or: got %h/%b want fff0fff0/0001", bus.alu_out, bus.aluctl); end
        drive(rtype(FN_XOR), 32'hF0F0F0F0, 32'hFF00FF00);
        n_checks++; if (bus.alu_out !== 32'h0FF00FF0 || bus.aluctl !== 4'b1101) begin n_fail++; $display("FAIL xor: got %h/%b want 0ff00ff0/1101", bus.alu_out, bus.aluctl); end
        drive(rtype(FN_NOR), 32'hF0F0F0F0, 32'hFF00FF00);
        n_checks++; if (bus.alu_out !== 32'h000F000F || bus.aluctl !== 4'b1100) begin n_fail++; $display("FAIL nor: got %h/%b want 000f000f/1100", bus.alu_out, bus.aluctl); end
        drive(rtype(FN_ADD), 32'hF0F0F0F0, 32'hFF00FF00);
        n_checks++; if (bus.alu_out !== 32'hEFF1EFF0) begin n_fail++; $display("FAIL add: got %h want eff1eff0", bus.alu_out); end
        drive(rtype(FN_ADD), 32'hFFFFFFFF, 32'd1);
        n_checks++; if (bus.alu_out !== 32'd0 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL add_wrap: got %h/%b want 0/1", bus.alu_out, bus.zero); end
    endtask

    task automatic test_itype;
        drive(itype(OP_ADDI, 16'h8000), 32'd10, 32'd99);
        n_checks++; if (ctl !== 9'b010001000) begin n_fail++; $display("FAIL addi_ctl: got %b want 010001000", ctl); end
        n_checks++; if (bus.alu_out !== 32'hFFFF800A) begin n_fail++; $display("FAIL addi_sext: got %h want ffff800a", bus.alu_out); end
        drive(itype(OP_SW, 16'h0004), 32'h20, 32'h55);
        n_checks++; if (ctl !== 9'b010100000 || bus.alu_out !== 32'h24) begin n_fail++; $display("FAIL sw: got %b/%h want 010100000/00000024", ctl, bus.alu_out); end
        drive({OP_J, 26'h0000123}, 32'd1, 32'd2);
        n_checks++; if (ctl !== 9'b000000001 || bus.aluctl !== 4'b0010) begin n_fail++; $display("FAIL j: got %b/%b want 000000001/0010", ctl, bus.aluctl); end
    endtask

    task automatic test_clear;
        drive(itype(OP_ADDI, 16'd7), 32'd0, 32'd0);
        bus.clear = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.alu_out_q !== 32'd0 || bus.zero_q !== 1'b0) begin n_fail++; $display("FAIL clear7: got %h/%b want 0/0", bus.alu_out_q, bus.zero_q); end
        drive(rtype(FN_SUB), 32'd3, 32'd3);
        @(posedge clk); #1;
        n_checks++; if (bus.zero_q !== 1'b0) begin n_fail++; $display("FAIL clear_zero: got %b want 0", bus.zero_q); end
        @(negedge clk);
        bus.clear = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.zero_q !== 1'b1) begin n_fail++; $display("FAIL clear_release: got %b want 1", bus.zero_q); end
    endtask

    task automatic test_async_reset;
        drive(itype(OP_ADDI, 16'd7), 32'd0, 32'd0);
        @(posedge clk); #1;
        n_checks++; if (bus.alu_out_q !== 32'd7) begin n_fail++; $display("FAIL pre_rst: got %h want 7", bus.alu_out_q); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.alu_out_q !== 32'd0 || bus.zero_q !== 1'b0) begin n_fail++; $display("FAIL async_rst: got %h/%b want 0/0", bus.alu_out_q, bus.zero_q); end
        n_checks++; if (bus.alu_out !== 32'd7) begin n_fail++; $display("FAIL rst_comb: got %h want 7", bus.alu_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.alu_out_q !== 32'd7) begin n_fail++; $display("FAIL post_rst: got %h want 7", bus.alu_out_q); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins [4];
        logic [31:0] av  [4];
        logic [31:0] bv  [4];
        logic [31:0] ev  [4];
        ins[0] = rtype(FN_ADD); av[0] = 32'd2;  bv[0] = 32'd3;  ev[0] = 32'd5;
        ins[1] = rtype(FN_SUB); av[1] = 32'd2;  bv[1] = 32'd3;  ev[1] = 32'hFFFFFFFF;
        ins[2] = rtype(FN_OR);  av[2] = 32'hA0; bv[2] = 32'h0B; ev[2] = 32'hAB;
        ins[3] = itype(OP_LW, 16'h0008); av[3] = 32'h10; bv[3] = 32'd0; ev[3] = 32'h18;
        for (int i = 0; i < 4; i++) begin
            drive(ins[i], av[i], bv[i]);
            @(posedge clk); #1;
            n_checks++; if (bus.alu_out_q !== ev[i]) begin n_fail++; $display("FAIL b2b_%0d: got %h want %h", i, bus.alu_out_q, ev[i]); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_lw();
        test_rtype_sub();
        test_slt();
        test_branch();
        test_nop_and_default();
        test_logic_ops();
        test_itype();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_decode_alu.md
MIPS_DECODE_ALU -- requirements
Module: mips_decode_alu

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 instr  input  32  instruction word; opcode = instr[31:26], funct = instr[5:0], imm = instr[15:0].
REQ-004 rs_data  input  32  ALU operand A.
REQ-005 rt_data  input  32  register operand B, used when alusrc=0.
REQ-006 clear  input  1  synchronous clear of the result register.
REQ-007 regdst, alusrc, memread, memwrite, memtoreg, regwrite, branch_eq, branch_ne, jump  output  1 each  combinational control decode.
REQ-008 aluop  output  2  combinational ALU-op class.
REQ-009 aluctl  output  4  combinational ALU operation select.
REQ-010 alu_out  output  32  combinational ALU result.
REQ-011 zero  output  1  combinational; 1 iff alu_out == 0.
REQ-012 alu_out_q  output  32  registered alu_out.
REQ-013 zero_q  output  1  registered zero.

Function
REQ-014 Control decode by opcode; a signal not listed for an opcode is 0.
- 000000 R-type: regdst=1, regwrite=1, aluop=10.
- 100011 lw: memread=1, memtoreg=1, alusrc=1, regwrite=1, aluop=00.
- 101011 sw: memwrite=1, alusrc=1, aluop=00.
- 001000 addi: alusrc=1, regwrite=1, aluop=00.
- 000100 beq: branch_eq=1, aluop=01.
- 000101 bne: branch_ne=1, aluop=01.
- 000010 j: jump=1, aluop=00.
REQ-015 Any other opcode SHALL decode as a NOP: every control output 0, aluop=00.
REQ-016 aluctl from aluop: 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 0000.
REQ-017 aluctl from funct when aluop=10:
- 100000 -> 0010 (add); 100010 -> 0110 (sub).
- 100100 -> 0000 (and); 100101 -> 0001 (or).
- 100110 -> 1101 (xor); 100111 -> 1100 (nor).
- 101010 -> 0111 (slt).
- any other funct -> 0000.
REQ-018 ALU operand B = alusrc ? sign-extended imm {16{imm[15]}, imm} : rt_data.
REQ-019 ALU operations on 32 bits:
- add, sub: wrap modulo 2^32; no overflow flag, no trap.
- and, or, xor, nor: bitwise.
- slt: signed two's-complement compare; result 32'd1 if A < B, else 32'd0.
REQ-020 aluctl codes not listed in REQ-017 SHALL produce alu_out = 0.
REQ-021 zero SHALL be derived from alu_out for every aluctl code, including unused codes (0 result -> zero=1).
REQ-022 Each rising clk: alu_out_q <= alu_out, zero_q <= zero; latency 1 cycle.
REQ-023 clear=1 at a rising edge SHALL load alu_out_q=0 and zero_q=0.
REQ-024 Register priority: rst_n low > clear > normal load.
REQ-025 Combinational outputs SHALL follow inputs with no dependence on state or reset.

Reset
REQ-026 rst_n=0 SHALL immediately force alu_out_q=0 and zero_q=0, independent of clk.
REQ-027 After rst_n deasserts, the first rising edge loads normally.
REQ-028 Reset asserted mid-operation SHALL discard the pending result.

Structure
REQ-029 Opcode, funct and aluctl encodings SHALL be named constants in a shared package (mips_pkg), used by the decoder, the ALU and the bench.
REQ-030 Implementation as three combinational sub-units plus an output register:
- control decoder;
- ALU-control decoder;
- one natural sub-module, mips_alu_core: aluctl, a, b -> out, zero.

Verification
REQ-031 lw (opcode 100011), rs_data=0x100, imm=0xFFFC -> memread=memtoreg=alusrc=regwrite=1, aluctl=0010, alu_out=0xFC; alu_out_q=0xFC one edge later.
REQ-032 R-type sub (funct 100010), rs_data=rt_data=0x1234 -> regdst=regwrite=1, aluctl=0110, alu_out=0, zero=1; zero_q=1 after one edge.
REQ-033 R-type slt, rs_data=0xFFFFFFFF, rt_data=1 -> alu_out=1; swap the operands -> alu_out=0.
REQ-034 beq, rs_data=5, rt_data=5 -> branch_eq=1, regwrite=0, zero=1; bne with rt_data=6 -> branch_ne=1, zero=0.
REQ-035 Opcode 111111 -> all control outputs 0; funct 000000 with aluop=10 -> aluctl=0000 (and).
REQ-036 Drive rst_n low between clock edges -> alu_out_q=0 and zero_q=0 immediately; clear=1 at an edge with alu_out=7 -> alu_out_q=0.
